// File: rtl/cavlc_coeff_scan_pkg.sv
// rtl/cavlc_coeff_scan_pkg.sv - shared state encoding, field widths and block-size constants
package cavlc_coeff_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HDR,
    ST_EMIT
  } state_t;

  localparam int MAX_COEFF = 16;

  localparam int TC_W  = 5;
  localparam int T1_W  = 2;
  localparam int TZ_W  = 4;
  localparam int RUN_W = 4;

  // Legal blk_max values: chroma DC, AC (DC coded separately), full 4x4
  localparam logic [4:0] BLK_MAX_CDC  = 5'd4;
  localparam logic [4:0] BLK_MAX_AC   = 5'd15;
  localparam logic [4:0] BLK_MAX_LUMA = 5'd16;

endpackage

// File: rtl/cavlc_lr_buf.sv
// rtl/cavlc_lr_buf.sv - 16-entry {level, run_before} register file, separate level/run write ports
module cavlc_lr_buf
  import cavlc_coeff_scan_pkg::*;
#(
  parameter int LEVEL_W = 16
) (
  input  logic                      clk,
  input  logic                      lvl_we,
  input  logic [3:0]                lvl_addr,
  input  logic signed [LEVEL_W-1:0] lvl_data,
  input  logic                      run_we,
  input  logic [3:0]                run_addr,
  input  logic [RUN_W-1:0]          run_data,
  input  logic [3:0]                rd_addr,
  output logic signed [LEVEL_W-1:0] rd_level,
  output logic [RUN_W-1:0]          rd_run
);

  logic signed [LEVEL_W-1:0] level_mem [MAX_COEFF];
  logic [RUN_W-1:0]          run_mem   [MAX_COEFF];

  always_ff @(posedge clk) begin
    if (lvl_we) level_mem[lvl_addr] <= lvl_data;
    if (run_we) run_mem[run_addr]   <= run_data;
  end

  assign rd_level = level_mem[rd_addr];
  assign rd_run   = run_mem[rd_addr];

endmodule

// File: rtl/cavlc_coeff_scan.sv
// rtl/cavlc_coeff_scan.sv - CAVLC block scan: header statistics then {level, run} stream.
// Optional CAVLC_LEVEL_SAT_EN clips stored levels to +/-(2^(LEVEL_W-1)-1).
module cavlc_coeff_scan
  import cavlc_coeff_scan_pkg::*;
#(
  parameter int COEFF_W = 16,
  parameter int LEVEL_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      blk_start,
  input  logic [4:0]                blk_max,
  output logic                      blk_ready,
  input  logic                      coeff_valid,
  input  logic signed [COEFF_W-1:0] coeff_data,
  output logic                      coeff_ready,
  output logic                      hdr_valid,
  input  logic                      hdr_ready,
  output logic [TC_W-1:0]           total_coeff,
  output logic [T1_W-1:0]           trailing_ones,
  output logic [TZ_W-1:0]           total_zeros,
  output logic [2:0]                t1_sign,
  output logic                      lr_valid,
  input  logic                      lr_ready,
  output logic signed [LEVEL_W-1:0] lr_level,
  output logic [RUN_W-1:0]          lr_run,
  output logic                      lr_last
);

  state_t            state, state_nx;
  logic [4:0]        max_q;
  logic [4:0]        idx;
  logic [TC_W-1:0]   tc;
  logic [TC_W-1:0]   tc_m1;
  logic [T1_W-1:0]   t1;
  logic [TZ_W-1:0]   zeros;
  logic [RUN_W-1:0]  run;
  logic              t1_closed;
  logic [2:0]        sign_q;

  logic              nz, is_one, last_coeff;
  logic              lvl_we, run_we;
  logic signed [LEVEL_W-1:0] level;
  logic signed [LEVEL_W-1:0] rd_level;
  logic [RUN_W-1:0]  rd_run;

  assign tc_m1      = tc - 5'd1;
  assign nz         = (coeff_data != '0);
  assign is_one     = (coeff_data == COEFF_W'(1)) || (coeff_data == '1);
  assign last_coeff = ((idx + 5'd1) == max_q);

`ifdef CAVLC_LEVEL_SAT_EN
  localparam logic signed [COEFF_W-1:0] LMAX = COEFF_W'((64'sd1 <<< (LEVEL_W - 1)) - 64'sd1);
  logic signed [COEFF_W-1:0] clip;
  always_comb begin
    clip = coeff_data;
    if (coeff_data > LMAX)       clip = LMAX;
    else if (coeff_data < -LMAX) clip = -LMAX;
  end
  assign level = clip[LEVEL_W-1:0];
`else
  assign level = coeff_data[LEVEL_W-1:0];
`endif

  always_comb begin
    state_nx    = state;
    blk_ready   = 1'b0;
    coeff_ready = 1'b0;
    hdr_valid   = 1'b0;
    lr_valid    = 1'b0;
    lvl_we      = 1'b0;
    run_we      = 1'b0;
    case (state)
      ST_IDLE: begin
        blk_ready = 1'b1;
        if (blk_start) state_nx = ST_SCAN;
      end
      ST_SCAN: begin
        coeff_ready = 1'b1;
        if (coeff_valid) begin
          lvl_we = nz;
          run_we = nz && (tc != '0);
          if (last_coeff) state_nx = ST_HDR;
        end
      end
      ST_HDR: begin
        hdr_valid = 1'b1;
        // Closes the run of the final stored entry; re-writing while stalled is harmless.
        run_we    = (tc != '0);
        if (hdr_ready) state_nx = (tc != '0) ? ST_EMIT : ST_IDLE;
      end
      ST_EMIT: begin
        lr_valid = 1'b1;
        if (lr_ready && lr_last) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      max_q     <= '0;
      idx       <= '0;
      tc        <= '0;
      t1        <= '0;
      zeros     <= '0;
      run       <= '0;
      t1_closed <= 1'b0;
      sign_q    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (blk_start) begin
          max_q     <= blk_max;
          idx       <= '0;
          tc        <= '0;
          t1        <= '0;
          zeros     <= '0;
          run       <= '0;
          t1_closed <= 1'b0;
          sign_q    <= '0;
        end
        ST_SCAN: if (coeff_valid) begin
          idx <= idx + 5'd1;
          if (nz) begin
            tc  <= tc + 5'd1;
            run <= '0;
            if (is_one && !t1_closed && (t1 != 2'd3)) begin
              sign_q[t1] <= coeff_data[COEFF_W-1];
              t1         <= t1 + 2'd1;
            end else begin
              t1_closed <= 1'b1;
            end
          end else if (tc != '0) begin
            zeros <= zeros + 4'd1;
            run   <= run + 4'd1;
          end
        end
        ST_HDR:  if (hdr_ready && (tc != '0)) idx <= '0;
        ST_EMIT: if (lr_ready) idx <= idx + 5'd1;
        default: ;
      endcase
    end
  end

  cavlc_lr_buf #(.LEVEL_W(LEVEL_W)) u_buf (
    .clk      (clk),
    .lvl_we   (lvl_we),
    .lvl_addr (tc[3:0]),
    .lvl_data (level),
    .run_we   (run_we),
    .run_addr (tc_m1[3:0]),
    .run_data (run),
    .rd_addr  (idx[3:0]),
    .rd_level (rd_level),
    .rd_run   (rd_run)
  );

  assign total_coeff   = tc;
  assign trailing_ones = t1;
  assign total_zeros   = zeros;
  assign t1_sign       = sign_q;
  assign lr_last       = (state == ST_EMIT) && (idx == tc_m1);
  assign lr_level      = (state == ST_EMIT) ? rd_level : '0;
  assign lr_run        = (state == ST_EMIT) ? rd_run : '0;

endmodule

// File: tb/tb_cavlc_coeff_scan.sv
// tb/tb_cavlc_coeff_scan.sv - directed and random blocks against a position-based CAVLC model
module tb_cavlc_coeff_scan;
  import cavlc_coeff_scan_pkg::*;

  localparam int COEFF_W = 16;
  localparam int LEVEL_W = 12;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      blk_start;
  logic [4:0]                blk_max;
  logic                      blk_ready;
  logic                      coeff_valid;
  logic signed [COEFF_W-1:0] coeff_data;
  logic                      coeff_ready;
  logic                      hdr_valid;
  logic                      hdr_ready;
  logic [4:0]                total_coeff;
  logic [1:0]                trailing_ones;
  logic [3:0]                total_zeros;
  logic [2:0]                t1_sign;
  logic                      lr_valid;
  logic                      lr_ready;
  logic signed [LEVEL_W-1:0] lr_level;
  logic [3:0]                lr_run;
  logic                      lr_last;

  cavlc_coeff_scan #(.COEFF_W(COEFF_W), .LEVEL_W(LEVEL_W)) dut (
    .clk(clk), .rst(rst), .blk_start(blk_start), .blk_max(blk_max), .blk_ready(blk_ready),
    .coeff_valid(coeff_valid), .coeff_data(coeff_data), .coeff_ready(coeff_ready),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .total_coeff(total_coeff),
    .trailing_ones(trailing_ones), .total_zeros(total_zeros), .t1_sign(t1_sign),
    .lr_valid(lr_valid), .lr_ready(lr_ready), .lr_level(lr_level), .lr_run(lr_run),
    .lr_last(lr_last)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic signed [15:0] stim [16];
  int e_tc, e_t1, e_tz, e_sign;
  int e_lv[$];
  int e_rn[$];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_lvl(input logic signed [15:0] v);
    logic signed [11:0] t;
`ifdef CAVLC_LEVEL_SAT_EN
    if (v > 16'sd2047) return 2047;
    if (v < -16'sd2047) return -2047;
    return int'(v);
`else
    t = v[11:0];
    return int'(t);
`endif
  endfunction

  // Model from nonzero positions in the reverse-order stream
  task automatic model(input int n);
    int pos[$];
    for (int i = 0; i < n; i++) if (stim[i] != 0) pos.push_back(i);
    e_tc = pos.size();
    e_tz = (e_tc > 0) ? (n - pos[0] - e_tc) : 0;
    e_t1 = 0;
    e_sign = 0;
    for (int k = 0; k < e_tc && k < 3; k++) begin
      if (stim[pos[k]] != 1 && stim[pos[k]] != -1) break;
      if (stim[pos[k]] < 0) e_sign |= (1 << k);
      e_t1++;
    end
    e_lv.delete();
    e_rn.delete();
    for (int k = 0; k < e_tc; k++) begin
      e_lv.push_back(exp_lvl(stim[pos[k]]));
      e_rn.push_back((k + 1 < e_tc) ? (pos[k+1] - pos[k] - 1) : (n - 1 - pos[k]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input int n, input int hold, input bit rand_lr, input bit rand_valid);
    int g, i, k;
    bit r;
    model(n);
    g = 0;
    while (!blk_ready && g < 50) begin cyc(); g++; end
    check("start_wait", blk_ready, 1);
    blk_start = 1'b1;
    blk_max = 5'(n);
    cyc();
    blk_start = 1'b0;
    i = 0;
    g = 0;
    while (i < n && g < 200) begin
      coeff_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      coeff_data  = coeff_valid ? stim[i] : 16'($urandom);
      r = coeff_ready;
      cyc();
      if (coeff_valid && r) i++;
      g++;
    end
    coeff_valid = 1'b0;
    check("feed_done", i, n);
    check("hdr_rise", hdr_valid, 1);
    for (int h = 0; h <= hold; h++) begin
      check("hdr_tc", total_coeff, e_tc);
      check("hdr_t1", trailing_ones, e_t1);
      check("hdr_tz", total_zeros, e_tz);
      check("hdr_sign", t1_sign, e_sign);
      check("hdr_valid", hdr_valid, 1);
      if (h == hold) hdr_ready = 1'b1;
      cyc();
    end
    hdr_ready = 1'b0;
    if (e_tc == 0) begin
      check("zero_lr_valid", lr_valid, 0);
      check("zero_blk_ready", blk_ready, 1);
    end else begin
      k = 0;
      g = 0;
      while (k < e_tc && g < 300) begin
        lr_ready = rand_lr ? 1'($urandom_range(0, 1)) : 1'b1;
        check("lr_valid", lr_valid, 1);
        if (lr_valid && lr_ready) begin
          check("lr_level", lr_level, e_lv[k]);
          check("lr_run", lr_run, e_rn[k]);
          check("lr_last", lr_last, (k == e_tc - 1) ? 1 : 0);
          k++;
        end
        cyc();
        g++;
      end
      lr_ready = 1'b0;
      check("emit_done", k, e_tc);
      if (!rand_lr) check("emit_cycles", g, e_tc);
      check("post_lr_valid", lr_valid, 0);
      check("post_blk_ready", blk_ready, 1);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 16; i++) stim[i] = '0;
  endtask

  task automatic rand_stim();
    int m, r;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 9);
      m = $urandom_range(2, 20);
      if (r < 5)      stim[i] = '0;
      else if (r < 8) stim[i] = $urandom_range(0, 1) ? 16'sd1 : -16'sd1;
      else if (r < 9) stim[i] = $urandom_range(0, 1) ? 16'(m) : 16'(-m);
      else            stim[i] = 16'($urandom);
    end
  endtask

  function automatic int rand_n();
    case ($urandom_range(0, 2))
      0:       return int'(BLK_MAX_CDC);
      1:       return int'(BLK_MAX_AC);
      default: return int'(BLK_MAX_LUMA);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    blk_start = 1'b0;
    blk_max = '0;
    coeff_valid = 1'b0;
    coeff_data = '0;
    hdr_ready = 1'b0;
    lr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_blk_ready", blk_ready, 1);
    check("rst_coeff_ready", coeff_ready, 0);
    check("rst_hdr_valid", hdr_valid, 0);
    check("rst_lr_valid", lr_valid, 0);
    check("rst_tc", total_coeff, 0);
    check("rst_sign", t1_sign, 0);
    check("rst_lr_level", lr_level, 0);
    check("rst_lr_last", lr_last, 0);
    rst = 1'b0;
    cyc();

    // Mixed block, zigzag 0,3,-1,0,0,-1,1,0,1,0... fed in reverse
    stim = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, -1, 0, 0, -1, 3, 0};
    run_block(16, 3, 0, 0);

    clear_stim();
    run_block(15, 0, 0, 0);

    clear_stim();
    stim[0] = 5; stim[1] = 1; stim[2] = -1; stim[3] = 1;
    run_block(4, 1, 1, 0);

    clear_stim();
    stim[0] = 1; stim[1] = 1; stim[2] = -1; stim[3] = 1; stim[4] = -1;
    run_block(16, 0, 0, 1);

    clear_stim();
    stim[0] = -5000; stim[1] = 5000; stim[3] = 7;
    run_block(4, 0, 0, 0);

    // Reset on the 7th coefficient aborts the block
    clear_stim();
    stim[0] = 1; stim[1] = 2; stim[3] = -1; stim[5] = 4; stim[6] = 9;
    blk_start = 1'b1;
    blk_max = 5'd16;
    cyc();
    blk_start = 1'b0;
    coeff_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      coeff_data = stim[i];
      cyc();
    end
    coeff_data = stim[6];
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    coeff_valid = 1'b0;
    check("abort_blk_ready", blk_ready, 1);
    check("abort_coeff_ready", coeff_ready, 0);
    check("abort_hdr_valid", hdr_valid, 0);
    check("abort_lr_valid", lr_valid, 0);
    check("abort_tc", total_coeff, 0);
    check("abort_t1", trailing_ones, 0);
    check("abort_tz", total_zeros, 0);
    check("abort_sign", t1_sign, 0);
    check("abort_lr_run", lr_run, 0);
    rand_stim();
    run_block(16, 0, 0, 0);

    for (int b = 0; b < 40; b++) begin
      rand_stim();
      run_block(rand_n(), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
